nic_flit_injector: RTL and testbench

NIC_FLIT_INJECTOR -- requirements
Module: nic_flit_injector

---
 rtl/nic_flit_injector_if.sv | 32 +++
 rtl/nic_flit_injector.sv | 111 +++++++++++
 tb/tb_nic_flit_injector.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nic_flit_injector_if.sv
// rtl/nic_flit_injector_if.sv - staging-queue, credit and link signals of the NIC flit injector
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

interface nic_flit_injector_if #(
  parameter int N_TOT_OF_VC = 6,
  parameter int CREDIT_BITS = 3,
  parameter int FLIT_WIDTH  = `FLIT_WIDTH
);
  logic [N_TOT_OF_VC*FLIT_WIDTH-1:0]  flit_data_i;
  logic [N_TOT_OF_VC-1:0]             flit_valid_i;
  logic [N_TOT_OF_VC-1:0]             flit_is_tail_i;
  logic [N_TOT_OF_VC-1:0]             flit_pop_o;
  logic [N_TOT_OF_VC-1:0]             vc_busy_i;
  logic [N_TOT_OF_VC-1:0]             credit_signal_i;
  logic [FLIT_WIDTH-1:0]              out_link_o;
  logic                               is_valid_o;
  logic [N_TOT_OF_VC-1:0]             release_pointer_o;
  logic [N_TOT_OF_VC*CREDIT_BITS-1:0] credit_count_o;
  logic                               credit_err_o;

  modport master (
    output flit_data_i, flit_valid_i, flit_is_tail_i, vc_busy_i, credit_signal_i,
    input  flit_pop_o, out_link_o, is_valid_o, release_pointer_o, credit_count_o, credit_err_o
  );

  modport slave (
    input  flit_data_i, flit_valid_i, flit_is_tail_i, vc_busy_i, credit_signal_i,
    output flit_pop_o, out_link_o, is_valid_o, release_pointer_o, credit_count_o, credit_err_o
  );
endinterface

// File: rtl/nic_flit_injector.sv
// rtl/nic_flit_injector.sv - credit-gated round-robin VC arbiter feeding one registered NoC link
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module nic_flit_injector #(
  parameter int N_TOT_OF_VC  = 6,
  parameter int BUFFER_DEPTH = 4,
  parameter int CREDIT_BITS  = 3,
  parameter int FLIT_WIDTH   = `FLIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  nic_flit_injector_if.slave   nif
);
  localparam int PTR_W = (N_TOT_OF_VC > 1) ? $clog2(N_TOT_OF_VC) : 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0]       LAST_VC    = PTR_W'(N_TOT_OF_VC - 1);

  logic [CREDIT_BITS-1:0] credit_q [N_TOT_OF_VC];
  logic [CREDIT_BITS-1:0] credit_d [N_TOT_OF_VC];
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [FLIT_WIDTH-1:0]  out_link_q, out_link_d;
  logic                   is_valid_q, is_valid_d;
  logic [N_TOT_OF_VC-1:0] release_q, release_d;
  logic                   credit_err_q, credit_err_d;

  logic [N_TOT_OF_VC-1:0] elig;
  logic [N_TOT_OF_VC-1:0] grant;
  logic                   grant_found;
  logic [PTR_W-1:0]       grant_idx;

  // Gating with rst keeps pop low and freezes arbitration while in reset.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      elig[i] = rst & nif.vc_busy_i[i] & nif.flit_valid_i[i] & (credit_q[i] != '0);
    end
  end

  always_comb begin : arbiter
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = 0; k < N_TOT_OF_VC; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= N_TOT_OF_VC) cand = cand - N_TOT_OF_VC;
      cand_idx = PTR_W'(cand);
      if (!grant_found && elig[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    out_link_d   = out_link_q;
    is_valid_d   = grant_found;
    release_d    = grant & nif.flit_is_tail_i;
    credit_err_d = credit_err_q;
    if (grant_found) begin
      rr_ptr_d   = (grant_idx == LAST_VC) ? '0 : grant_idx + 1'b1;
      out_link_d = nif.flit_data_i[grant_idx*FLIT_WIDTH +: FLIT_WIDTH];
    end
    // A simultaneous grant and credit return cancel out.
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      credit_d[i] = credit_q[i];
      if (nif.credit_signal_i[i] && !grant[i]) begin
        if (credit_q[i] == CREDIT_MAX) credit_err_d = 1'b1;
        else                           credit_d[i]  = credit_q[i] + 1'b1;
      end else if (!nif.credit_signal_i[i] && grant[i]) begin
        if (credit_q[i] == '0) credit_err_d = 1'b1;
        else                   credit_d[i]  = credit_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_TOT_OF_VC; i++) credit_q[i] <= CREDIT_MAX;
      rr_ptr_q     <= '0;
      out_link_q   <= '0;
      is_valid_q   <= 1'b0;
      release_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_TOT_OF_VC; i++) credit_q[i] <= credit_d[i];
      rr_ptr_q     <= rr_ptr_d;
      out_link_q   <= out_link_d;
      is_valid_q   <= is_valid_d;
      release_q    <= release_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign nif.flit_pop_o        = grant;
  assign nif.out_link_o        = out_link_q;
  assign nif.is_valid_o        = is_valid_q;
  assign nif.release_pointer_o = release_q;
  assign nif.credit_err_o      = credit_err_q;

  for (genvar gi = 0; gi < N_TOT_OF_VC; gi++) begin : g_credit_out
    assign nif.credit_count_o[gi*CREDIT_BITS +: CREDIT_BITS] = credit_q[gi];
  end
endmodule

// File: tb/tb_nic_flit_injector.sv
// tb/tb_nic_flit_injector.sv - scoreboard bench for nic_flit_injector
module tb_nic_flit_injector;
  localparam int N  = 6;
  localparam int D  = 4;
  localparam int CB = 3;
  localparam int FW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nic_flit_injector_if #(.N_TOT_OF_VC(N), .CREDIT_BITS(CB), .FLIT_WIDTH(FW)) nif ();

  nic_flit_injector #(
    .N_TOT_OF_VC(N), .BUFFER_DEPTH(D), .CREDIT_BITS(CB), .FLIT_WIDTH(FW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .nif (nif.slave)
  );

  typedef struct packed {
    logic          valid;
    logic [N-1:0]  rel;
    logic [FW-1:0] link;
  } exp_t;

  exp_t sb[$];

  int            checks   = 0;
  int            failures = 0;
  int            m_credit [N];
  int            m_rr;
  logic          m_err;
  logic [FW-1:0] m_link;
  int            pkt_left [N];
  int            seq      [N];
  logic [N-1:0]  busy;
  logic [N-1:0]  cred_in;
  int            pop_cnt  [N];
  int            rel_cnt  [N];
  int            order_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [FW-1:0] flit_of(input int i);
    logic [31:0] vi;
    logic [31:0] si;
    vi = i;
    si = seq[i];
    return {vi[7:0], si[23:0]};
  endfunction

  function automatic logic [N*CB-1:0] model_credits();
    logic [N*CB-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*CB +: CB] = CB'(m_credit[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_credit[i] = D;
    m_rr   = 0;
    m_err  = 1'b0;
    m_link = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      nif.vc_busy_i[i]                = busy[i];
      nif.flit_valid_i[i]             = (pkt_left[i] > 0);
      nif.flit_is_tail_i[i]           = (pkt_left[i] == 1);
      nif.flit_data_i[i*FW +: FW]     = flit_of(i);
    end
    nif.credit_signal_i = cred_in;
  endtask

  task automatic tick();
    int           g;
    exp_t         e;
    logic [N-1:0] exp_pop;
    drive();
    #2;
    g = -1;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (g < 0 && busy[c] && pkt_left[c] > 0 && m_credit[c] != 0) g = c;
      end
    end
    exp_pop = (g >= 0) ? (N'(1) << g) : '0;
    chk("flit_pop", 64'(nif.flit_pop_o), 64'(exp_pop));
    for (int i = 0; i < N; i++) begin
      if (nif.flit_pop_o[i]) begin
        pop_cnt[i]++;
        order_log.push_back(i);
      end
    end
    if (!rst) begin
      model_reset();
      e = '0;
    end else begin
      e.valid = (g >= 0);
      e.rel   = (g >= 0 && pkt_left[g] == 1) ? exp_pop : '0;
      if (g >= 0) m_link = flit_of(g);
      e.link  = m_link;
      for (int i = 0; i < N; i++) begin
        if (cred_in[i] && g != i) begin
          if (m_credit[i] == D) m_err = 1'b1;
          else                  m_credit[i]++;
        end else if (!cred_in[i] && g == i) begin
          m_credit[i]--;
        end
      end
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (pkt_left[g] == 1) busy[g] = 1'b0;
        pkt_left[g]--;
        seq[g]++;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("is_valid", 64'(nif.is_valid_o), 64'(e.valid));
    chk("release", 64'(nif.release_pointer_o), 64'(e.rel));
    chk("out_link", 64'(nif.out_link_o), 64'(e.link));
    chk("credits", 64'(nif.credit_count_o), 64'(model_credits()));
    chk("credit_err", 64'(nif.credit_err_o), 64'(m_err));
    for (int i = 0; i < N; i++) if (nif.release_pointer_o[i]) rel_cnt[i]++;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      pop_cnt[i] = 0;
      rel_cnt[i] = 0;
    end
    order_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic int credit_of(input int i);
    return int'(nif.credit_count_o[i*CB +: CB]);
  endfunction

  initial begin
    int order_exp [6];
    order_exp = '{0, 1, 3, 0, 1, 3};
    busy    = '0;
    cred_in = '0;
    for (int i = 0; i < N; i++) begin
      pkt_left[i] = 0;
      seq[i]      = i * 16;
    end
    model_reset();
    clear_stats();

    rst = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(nif.is_valid_o), 64'd0);
    chk("rst_credit0", 64'(credit_of(0)), 64'd4);
    rst = 1'b1;

    // VC2 alone, 3-flit packet
    busy[2] = 1'b1;
    pkt_left[2] = 3;
    for (int t = 0; t < 5; t++) tick();
    chk("vc2_pops", 64'(pop_cnt[2]), 64'd3);
    chk("vc2_releases", 64'(rel_cnt[2]), 64'd1);
    chk("vc2_credit", 64'(credit_of(2)), 64'd1);
    do_reset();

    // VC0, VC1, VC3 contending: round-robin wrap
    clear_stats();
    busy[0] = 1'b1; busy[1] = 1'b1; busy[3] = 1'b1;
    pkt_left[0] = 50; pkt_left[1] = 50; pkt_left[3] = 50;
    for (int t = 0; t < 6; t++) tick();
    chk("rr_len", 64'(order_log.size()), 64'd6);
    for (int t = 0; t < 6 && t < order_log.size(); t++) chk("rr_order", 64'(order_log[t]), 64'(order_exp[t]));
    busy = '0;
    pkt_left[0] = 0; pkt_left[1] = 0; pkt_left[3] = 0;
    do_reset();

    // VC4 runs out of credits, then one credit buys one flit
    clear_stats();
    busy[4] = 1'b1;
    pkt_left[4] = 20;
    for (int t = 0; t < 7; t++) tick();
    chk("vc4_grants", 64'(pop_cnt[4]), 64'd4);
    chk("vc4_credit0", 64'(credit_of(4)), 64'd0);
    cred_in[4] = 1'b1;
    tick();
    cred_in = '0;
    clear_stats();
    for (int t = 0; t < 4; t++) tick();
    chk("vc4_one_more", 64'(pop_cnt[4]), 64'd1);
    busy = '0;
    pkt_left[4] = 0;
    do_reset();

    // Grant and return on VC1 together; overflow on VC5
    busy[1] = 1'b1;
    pkt_left[1] = 10;
    tick();
    cred_in[1] = 1'b1;
    tick();
    cred_in = '0;
    chk("vc1_unchanged", 64'(credit_of(1)), 64'd3);
    busy = '0;
    pkt_left[1] = 0;
    cred_in[5] = 1'b1;
    tick();
    cred_in = '0;
    chk("vc5_sat", 64'(credit_of(5)), 64'd4);
    chk("err_set", 64'(nif.credit_err_o), 64'd1);
    tick();
    tick();
    chk("err_sticky", 64'(nif.credit_err_o), 64'd1);
    do_reset();
    chk("err_cleared", 64'(nif.credit_err_o), 64'd0);

    // Reset in the middle of a VC3 packet
    clear_stats();
    busy[3] = 1'b1;
    pkt_left[3] = 3;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_valid", 64'(nif.is_valid_o), 64'd0);
    chk("mid_rst_release", 64'(nif.release_pointer_o), 64'd0);
    chk("mid_rst_credit3", 64'(credit_of(3)), 64'd4);
    rst = 1'b1;
    for (int t = 0; t < 4; t++) tick();
    chk("mid_rst_pops", 64'(pop_cnt[3]), 64'd3);

    // Random traffic with credit returns
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!busy[i] && pkt_left[i] == 0 && ($urandom % 4) == 0) begin
          busy[i]     = 1'b1;
          pkt_left[i] = $urandom_range(1, 4);
        end
        cred_in[i] = (m_credit[i] < D) && (($urandom % 3) == 0);
      end
      rst = (t != 200);
      tick();
    end
    rst = 1'b1;
    cred_in = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
